// File: rtl/dlx_div_pkg.sv
// Shared types and helpers for the DLX divider arbiter: FSM encoding,
// datapath width and the sign-conditioning functions used around the divider.
package dlx_div_pkg;

    localparam int DIV_W = 32;
    localparam logic [DIV_W-1:0] DBZ_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } div_state_t;

    // INT_MIN maps onto itself, which is exactly 2^31 when read as unsigned.
    function automatic logic [DIV_W-1:0] cond_abs(input logic [DIV_W-1:0] x,
                                                  input logic             is_signed);
        return (is_signed && x[DIV_W-1]) ? (DIV_W'(0) - x) : x;
    endfunction

    function automatic logic [DIV_W-1:0] cond_neg(input logic [DIV_W-1:0] x,
                                                  input logic             neg);
        return neg ? (DIV_W'(0) - x) : x;
    endfunction

endpackage

// File: rtl/div_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping, returned both one-hot and as an index.
module div_rr_arbiter
    import dlx_div_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;

    // Rotating a doubled copy puts the port at ptr into bit 0.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[NUM_REQ-1:0];

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise an untaken branch infers a latch.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (req_rot[off]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'((int'(ptr) + off) % NUM_REQ);
            end
        end
        grant = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one multicycle unsigned divider between NUM_REQ requesters with
// round-robin grant, signed operand conditioning, divide-by-zero bypass and a watchdog.
module div_arbiter
    import dlx_div_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int WDOG_CYCLES = 40
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_signed,
    input  logic [NUM_REQ*DIV_W-1:0] req_opa,
    input  logic [NUM_REQ*DIV_W-1:0] req_opb,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [DIV_W-1:0]         rsp_quot,
    output logic [DIV_W-1:0]         rsp_rem,
    output logic                     rsp_dbz,
    output logic                     rsp_err,
    output logic                     div_start,
    output logic [DIV_W-1:0]         div_opa,
    output logic [DIV_W-1:0]         div_opb,
    input  logic                     div_ready,
    input  logic [2*DIV_W-1:0]       div_result
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WDOG_W = $clog2(WDOG_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);

    div_state_t state, state_next;

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   arb_idx;
    logic [NUM_REQ-1:0] arb_grant;
    logic               arb_valid;
    logic [NUM_REQ-1:0] rsp_onehot;

    logic               sel_signed;
    logic [DIV_W-1:0]   sel_opa;
    logic [DIV_W-1:0]   sel_opb;
    logic               sel_dbz;

    logic               accept;
    logic               handshake;
    logic               neg_q;
    logic               neg_r;
    logic [WDOG_W-1:0]  wdog;
    logic               wdog_expired;
    logic [DIV_W-1:0]   res_quot;
    logic [DIV_W-1:0]   res_rem;

    div_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_comb begin
        sel_signed = 1'b0;
        sel_opa    = '0;
        sel_opb    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_signed = req_signed[i];
                sel_opa    = req_opa[i*DIV_W +: DIV_W];
                sel_opb    = req_opb[i*DIV_W +: DIV_W];
            end
        end
    end

    assign sel_dbz      = (sel_opb == '0);
    assign rsp_onehot   = NUM_REQ'(1) << gnt_idx;
    assign wdog_expired = (wdog == WDOG_LAST);

    // Divider works on magnitudes; signs are restored on the way back.
    assign res_quot = cond_neg(div_result[DIV_W-1:0], neg_q);
    assign res_rem  = cond_neg(div_result[2*DIV_W-1:DIV_W], neg_r);

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        div_start  = 1'b0;
        accept     = 1'b0;
        handshake  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    req_ready  = arb_grant;
                    accept     = 1'b1;
                    state_next = sel_dbz ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                div_start  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_ready || wdog_expired) state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = rsp_onehot;
                if (|(rsp_ready & rsp_onehot)) begin
                    handshake  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr   <= '0;
            gnt_idx  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            wdog     <= '0;
            div_opa  <= '0;
            div_opb  <= '0;
            rsp_quot <= '0;
            rsp_rem  <= '0;
            rsp_dbz  <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        gnt_idx <= arb_idx;
                        neg_q   <= sel_signed & (sel_opa[DIV_W-1] ^ sel_opb[DIV_W-1]);
                        neg_r   <= sel_signed & sel_opa[DIV_W-1];
                        if (sel_dbz) begin
                            rsp_quot <= DBZ_QUOT;
                            rsp_rem  <= sel_opa;
                            rsp_dbz  <= 1'b1;
                            rsp_err  <= 1'b0;
                        end else begin
                            div_opa <= cond_abs(sel_opa, sel_signed);
                            div_opb <= cond_abs(sel_opb, sel_signed);
                        end
                    end
                end
                ST_ISSUE: wdog <= '0;
                ST_WAIT: begin
                    if (div_ready) begin
                        rsp_quot <= res_quot;
                        rsp_rem  <= res_rem;
                        rsp_dbz  <= 1'b0;
                        rsp_err  <= 1'b0;
                    end else if (wdog_expired) begin
                        rsp_quot <= '0;
                        rsp_rem  <= '0;
                        rsp_dbz  <= 1'b0;
                        rsp_err  <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (handshake) rr_ptr <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: behavioural divider model plus a
// reference of signed/unsigned division, round-robin order and timing.
module tb_div_arbiter;

    localparam int N   = 2;
    localparam int W   = 40;
    localparam int OPW = 32 * N;

    logic             clock = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     req_signed;
    logic [OPW-1:0]   req_opa;
    logic [OPW-1:0]   req_opb;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [31:0]      rsp_quot;
    logic [31:0]      rsp_rem;
    logic             rsp_dbz;
    logic             rsp_err;
    logic             div_start;
    logic [31:0]      div_opa;
    logic [31:0]      div_opb;
    logic             div_ready;
    logic [63:0]      div_result;

    int checks = 0;
    int errors = 0;
    int exp_ptr = 0;

    // divider model controls and observations
    int          div_lat = 4;
    bit          div_hold = 1'b0;
    int          poke_count = 0;
    int          poke_seen = 0;
    int          n_starts = 0;
    int          busy_viol = 0;
    logic        m_busy;
    int          m_cnt;
    logic [31:0] m_a;
    logic [31:0] m_b;

    always #5 clock = ~clock;

    div_arbiter #(
        .NUM_REQ     (N),
        .WDOG_CYCLES (W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_signed (req_signed),
        .req_opa    (req_opa),
        .req_opb    (req_opb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_quot   (rsp_quot),
        .rsp_rem    (rsp_rem),
        .rsp_dbz    (rsp_dbz),
        .rsp_err    (rsp_err),
        .div_start  (div_start),
        .div_opa    (div_opa),
        .div_opb    (div_opb),
        .div_ready  (div_ready),
        .div_result (div_result)
    );

    // Divider: ready appears div_lat cycles after the start cycle; result is garbage otherwise.
    always @(posedge clock) begin
        if (reset) begin
            div_ready  <= 1'b0;
            div_result <= '0;
            m_busy     <= 1'b0;
            m_cnt      <= 0;
        end else begin
            div_ready  <= 1'b0;
            div_result <= {$urandom, $urandom};
            if (poke_count != poke_seen) begin
                poke_seen  <= poke_count;
                div_ready  <= 1'b1;
            end
            if (div_start) begin
                n_starts <= n_starts + 1;
                if (m_busy) busy_viol <= busy_viol + 1;
                m_a <= div_opa;
                m_b <= div_opb;
                if (!div_hold) begin
                    m_busy <= 1'b1;
                    m_cnt  <= div_lat - 1;
                end
            end else if (m_busy) begin
                if (m_cnt <= 1) begin
                    div_ready  <= 1'b1;
                    div_result <= (m_b == 0) ? 64'd0 : {m_a % m_b, m_a / m_b};
                    m_busy     <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output logic dbz);
        longint sa, sb;
        dbz = (b == 32'd0);
        if (dbz) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic [31:0] ref_mag(input logic s, input logic [31:0] x);
        longint sx;
        sx = longint'($signed(x));
        return (s && sx < 0) ? 32'(-sx) : x;
    endfunction

    task automatic drive_req(input int port, input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [N-1:0]   m;
        logic [OPW-1:0] lane;
        m          = N'(1) << port;
        lane       = OPW'(32'hFFFF_FFFF) << (32 * port);
        req_valid  = req_valid | m;
        req_signed = s ? (req_signed | m) : (req_signed & ~m);
        req_opa    = (req_opa & ~lane) | (OPW'(a) << (32 * port));
        req_opb    = (req_opb & ~lane) | (OPW'(b) << (32 * port));
    endtask

    task automatic drop_req(input int port);
        req_valid = req_valid & ~(N'(1) << port);
    endtask

    // One complete transaction on one port; lat counts cycles from accept to rsp_valid.
    task automatic run_op(input int port, input logic s, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output logic dbz,
                          output logic err, output int lat, output bit got);
        logic [N-1:0] m;
        int k;
        m = N'(1) << port;
        got = 1'b0; q = '0; r = '0; dbz = 1'b0; err = 1'b0; lat = 0;
        @(negedge clock);
        drive_req(port, s, a, b);
        #1;
        k = 0;
        while ((req_ready & m) == 0 && k < 200) begin
            @(negedge clock);
            k++;
        end
        if ((req_ready & m) == 0) begin
            checks++; errors++;
            $display("FAIL grant_wait port%0d: req_ready=%b never granted", port, req_ready);
            drop_req(port);
            return;
        end
        @(negedge clock);
        drop_req(port);
        lat = 1;
        while ((rsp_valid & m) == 0 && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        if ((rsp_valid & m) == 0) begin
            checks++; errors++;
            $display("FAIL rsp_wait port%0d: rsp_valid=%b after %0d cycles", port, rsp_valid, lat);
            return;
        end
        q = rsp_quot; r = rsp_rem; dbz = rsp_dbz; err = rsp_err;
        got = 1'b1;
        rsp_ready = m;
        @(negedge clock);
        rsp_ready = '0;
        exp_ptr = (port + 1) % N;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_valid = '0; req_signed = '0; req_opa = '0; req_opb = '0; rsp_ready = '0;
        repeat (3) @(negedge clock);
        checks++;
        if (rsp_valid !== '0 || div_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rsp_valid=%b div_start=%b, want 0/0", rsp_valid, div_start);
        end
        checks++;
        if ({div_opa, div_opb} !== 64'd0) begin
            errors++;
            $display("FAIL reset_divops: opa=%h opb=%h, want 0", div_opa, div_opb);
        end
        checks++;
        if ({rsp_quot, rsp_rem, rsp_dbz, rsp_err} !== 66'd0) begin
            errors++;
            $display("FAIL reset_rsp: quot=%h rem=%h dbz=%b err=%b, want 0", rsp_quot, rsp_rem, rsp_dbz, rsp_err);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0) begin
            errors++;
            $display("FAIL reset_idle: req_ready=%b rsp_valid=%b, want 0", req_ready, rsp_valid);
        end
    endtask

    typedef struct {
        int          port;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          dlat;
    } dcase_t;

    task automatic test_directed;
        dcase_t      tc[7];
        logic [31:0] q, r;
        logic        dbz, err;
        int          lat, starts0, want_lat;
        bit          got;
        tc[0] = '{0, 1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 5};
        tc[1] = '{1, 1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 8};
        tc[2] = '{0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33};
        tc[3] = '{1, 1'b0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1,          1'b0, 20};
        tc[4] = '{0, 1'b0, 32'd0,          32'd9,          32'd0,          32'd0,          1'b0, 2};
        tc[5] = '{1, 1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 2};
        tc[6] = '{0, 1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1, 2};
        for (int i = 0; i < 7; i++) begin
            div_lat = tc[i].dlat;
            starts0 = n_starts;
            run_op(tc[i].port, tc[i].s, tc[i].a, tc[i].b, q, r, dbz, err, lat, got);
            if (!got) continue;
            checks++;
            if ({q, r, dbz, err} !== {tc[i].q, tc[i].r, tc[i].dbz, 1'b0}) begin
                errors++;
                $display("FAIL directed%0d_result: quot=%h rem=%h dbz=%b err=%b, want %h %h %b 0",
                         i, q, r, dbz, err, tc[i].q, tc[i].r, tc[i].dbz);
            end
            want_lat = tc[i].dbz ? 1 : tc[i].dlat + 2;
            checks++;
            if (lat != want_lat) begin
                errors++;
                $display("FAIL directed%0d_latency: %0d cycles, want %0d", i, lat, want_lat);
            end
            if (tc[i].dbz) begin
                checks++;
                if (n_starts != starts0) begin
                    errors++;
                    $display("FAIL directed%0d_dbz_nostart: %0d starts, want 0", i, n_starts - starts0);
                end
            end else begin
                checks++;
                if ({m_a, m_b} !== {ref_mag(tc[i].s, tc[i].a), ref_mag(tc[i].s, tc[i].b)}) begin
                    errors++;
                    $display("FAIL directed%0d_divops: opa=%h opb=%h, want %h %h", i, m_a, m_b,
                             ref_mag(tc[i].s, tc[i].a), ref_mag(tc[i].s, tc[i].b));
                end
            end
        end
    endtask

    function automatic logic [31:0] pick_operand(input bit allow_zero);
        case ($urandom_range(0, 6))
            0:       return allow_zero ? 32'd0 : 32'd3;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 50));
            4:       return 32'(-int'($urandom_range(1, 50)));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random;
        logic [31:0] a, b, q, r, eq, er;
        logic        s, dbz, err, edbz;
        int          port, lat, want_lat;
        bit          got;
        for (int i = 0; i < 40; i++) begin
            port    = int'($urandom_range(0, N - 1));
            s       = 1'($urandom_range(0, 1));
            a       = pick_operand(1'b1);
            b       = pick_operand(($urandom_range(0, 4) == 0));
            div_lat = int'($urandom_range(2, 33));
            ref_div(s, a, b, eq, er, edbz);
            run_op(port, s, a, b, q, r, dbz, err, lat, got);
            if (!got) continue;
            checks++;
            if ({q, r, dbz, err} !== {eq, er, edbz, 1'b0}) begin
                errors++;
                $display("FAIL random%0d_result s=%b %h/%h: quot=%h rem=%h dbz=%b err=%b, want %h %h %b 0",
                         i, s, a, b, q, r, dbz, err, eq, er, edbz);
            end
            want_lat = edbz ? 1 : div_lat + 2;
            checks++;
            if (lat != want_lat) begin
                errors++;
                $display("FAIL random%0d_latency: %0d cycles, want %0d", i, lat, want_lat);
            end
        end
    endtask

    task automatic test_round_robin;
        int          exp, k;
        logic        bad;
        logic [31:0] eq;
        exp = exp_ptr;
        div_lat = 3;
        @(negedge clock);
        drive_req(0, 1'b0, 32'd100, 32'd7);
        drive_req(1, 1'b0, 32'd1000, 32'd10);
        #1;
        for (int n = 0; n < 4; n++) begin
            k = 0;
            while (req_ready == '0 && k < 100) begin
                @(negedge clock);
                k++;
            end
            checks++;
            if (req_ready !== (N'(1) << exp)) begin
                errors++;
                $display("FAIL rr_grant%0d: req_ready=%b, want port %0d", n, req_ready, exp);
            end
            @(negedge clock);
            bad = 1'b0;
            k = 0;
            while (rsp_valid == '0 && k < 100) begin
                if (req_ready != '0) bad = 1'b1;
                @(negedge clock);
                k++;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL rr_overlap%0d: req_ready=1 while busy, want 0", n);
            end
            checks++;
            if (rsp_valid !== (N'(1) << exp)) begin
                errors++;
                $display("FAIL rr_rsp%0d: rsp_valid=%b, want port %0d", n, rsp_valid, exp);
            end
            eq = (exp == 0) ? 32'd14 : 32'd100;
            checks++;
            if (rsp_quot !== eq) begin
                errors++;
                $display("FAIL rr_quot%0d: quot=%h, want %h", n, rsp_quot, eq);
            end
            rsp_ready = rsp_valid;
            @(negedge clock);
            rsp_ready = '0;
            exp = (exp + 1) % N;
        end
        drop_req(0);
        drop_req(1);
        exp_ptr = exp;
    endtask

    task automatic test_stall;
        int   k;
        logic [1:0] m;
        m = 2'b10;
        div_lat = 3;
        @(negedge clock);
        drive_req(1, 1'b0, 32'd77, 32'd10);
        #1;
        k = 0;
        while ((req_ready & m) == 0 && k < 100) begin
            @(negedge clock);
            k++;
        end
        @(negedge clock);
        drop_req(1);
        k = 0;
        while ((rsp_valid & m) == 0 && k < 100) begin
            @(negedge clock);
            k++;
        end
        for (int c = 0; c < 10; c++) begin
            rsp_ready = (c % 2 == 0) ? 2'b01 : 2'b00;
            checks++;
            if ({rsp_valid, rsp_quot, rsp_rem, rsp_dbz, rsp_err} !== {m, 32'd7, 32'd7, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall_cycle%0d: valid=%b quot=%h rem=%h dbz=%b err=%b, want 10 7 7 0 0",
                         c, rsp_valid, rsp_quot, rsp_rem, rsp_dbz, rsp_err);
            end
            @(negedge clock);
        end
        rsp_ready = m;
        @(negedge clock);
        rsp_ready = '0;
        checks++;
        if (rsp_valid !== '0) begin
            errors++;
            $display("FAIL stall_release: rsp_valid=%b after ack, want 0", rsp_valid);
        end
        exp_ptr = 0;
    endtask

    task automatic test_timeout;
        logic [31:0] q, r;
        logic        dbz, err;
        int          lat;
        bit          got;
        div_hold = 1'b1;
        run_op(0, 1'b0, 32'd50, 32'd3, q, r, dbz, err, lat, got);
        div_hold = 1'b0;
        if (got) begin
            checks++;
            if ({q, r, dbz, err} !== {32'd0, 32'd0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL timeout_result: quot=%h rem=%h dbz=%b err=%b, want 0 0 0 1", q, r, dbz, err);
            end
            checks++;
            if (lat != W + 2) begin
                errors++;
                $display("FAIL timeout_latency: %0d cycles, want %0d", lat, W + 2);
            end
        end
        div_lat = 6;
        run_op(1, 1'b0, 32'd9, 32'd3, q, r, dbz, err, lat, got);
        if (got) begin
            checks++;
            if ({q, r, dbz, err} !== {32'd3, 32'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL timeout_recover: quot=%h rem=%h dbz=%b err=%b, want 3 0 0 0", q, r, dbz, err);
            end
        end
    endtask

    task automatic test_reset_in_wait;
        int   k;
        logic bad;
        div_lat = 30;
        @(negedge clock);
        drive_req(1, 1'b0, 32'd500, 32'd3);
        #1;
        k = 0;
        while ((req_ready & 2'b10) == 0 && k < 100) begin
            @(negedge clock);
            k++;
        end
        @(negedge clock);
        drop_req(1);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_ptr = 0;
        checks++;
        if ({rsp_quot, rsp_rem, div_opa, div_opb} !== 128'd0) begin
            errors++;
            $display("FAIL midreset_regs: quot=%h rem=%h opa=%h opb=%h, want 0", rsp_quot, rsp_rem, div_opa, div_opb);
        end
        bad = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (rsp_valid != '0 || div_start) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL midreset_drop: response or start seen after reset, want none");
        end
        poke_count++;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (rsp_valid != '0 || req_ready != '0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stray_ready: stray div_ready produced activity, want none");
        end
        drive_req(0, 1'b0, 32'd21, 32'd4);
        drive_req(1, 1'b0, 32'd21, 32'd4);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL midreset_ptr: req_ready=%b, want 01", req_ready);
        end
        drop_req(0);
        drop_req(1);
    endtask

    task automatic test_divider_protocol;
        @(negedge clock);
        checks++;
        if (busy_viol != 0) begin
            errors++;
            $display("FAIL div_busy_restart: %0d starts while busy, want 0", busy_viol);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_round_robin();
        test_stall();
        test_timeout();
        test_reset_in_wait();
        test_divider_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish within 1 ms");
        $fatal(1, "timeout");
    end

endmodule
